// File: rtl/sockit_spi_arb_if.sv
// Queue handshake bundle (request/control/data out, grant back) shared by the
// two arbiter sources and the downstream queue port.
interface sockit_spi_arb_if #(
  parameter int QCI = 4,
  parameter int QDW = 32
) ();
  logic           req;
  logic [QCI-1:0] ctl;
  logic [QDW-1:0] dat;
  logic           grt;

  modport master (output req, ctl, dat, input grt);
  modport slave  (input req, ctl, dat, output grt);
endinterface

// File: rtl/sockit_spi_arb.sv
// Two-port per-packet arbiter in front of the SPI queue, with completed-packet counters.
// Build option: define SOCKIT_SPI_ARB_RR_EN for round-robin, otherwise port 0 has fixed priority.
module sockit_spi_arb #(
  parameter int SDW = 8,
  parameter int QCI = 4,
  parameter int QDW = 4*SDW,
  parameter int CNW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sockit_spi_arb_if.slave      s0,
  sockit_spi_arb_if.slave      s1,
  sockit_spi_arb_if.master     que,
  output logic [1:0]           arb_own,
  input  logic                 cnt_clr,
  output logic [CNW-1:0]       cnt0,
  output logic [CNW-1:0]       cnt1
);

  // Encoding doubles as the one-hot owner status.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic       pick1;
  logic [1:0] lst_done;

`ifdef SOCKIT_SPI_ARB_RR_EN
  // ptr_reg holds the last winner; on a tie the other port wins.
  logic ptr_reg;

  assign pick1 = s1.req & (~s0.req | ~ptr_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr_reg <= 1'b0;
    else if ((state_reg == IDLE) && (s0.req | s1.req))
      ptr_reg <= pick1;
  end
`else
  assign pick1 = s1.req & ~s0.req;
`endif

  assign lst_done[0] = (state_reg == OWN0) & s0.req & que.grt & s0.ctl[2];
  assign lst_done[1] = (state_reg == OWN1) & s1.req & que.grt & s1.ctl[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (s0.req | s1.req) state_next = pick1 ? OWN1 : OWN0;
      OWN0:    if (lst_done[0]) state_next = IDLE;
      OWN1:    if (lst_done[1]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pure pass-through from the owner; nothing registered in the data path.
  always_comb begin
    que.req = 1'b0;
    que.ctl = '0;
    que.dat = '0;
    s0.grt  = 1'b0;
    s1.grt  = 1'b0;
    case (state_reg)
      OWN0: begin
        que.req = s0.req;
        que.ctl = s0.ctl;
        que.dat = s0.dat;
        s0.grt  = que.grt;
      end
      OWN1: begin
        que.req = s1.req;
        que.ctl = s1.ctl;
        que.dat = s1.dat;
        s1.grt  = que.grt;
      end
      default: ;
    endcase
  end

  assign arb_own = state_reg;

  // Clear dominates a same-cycle increment; counters wrap naturally.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          cnt_reg <= '0;
        else if (cnt_clr)
          cnt_reg <= '0;
        else if (lst_done[gi])
          cnt_reg <= cnt_reg + CNW'(1);
      end
    end
  endgenerate

  assign cnt0 = g_cnt[0].cnt_reg;
  assign cnt1 = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Scoreboard bench for sockit_spi_arb: stimulus pushes expected queue beats,
// a negedge monitor pops and compares every queue transfer.
module tb_sockit_spi_arb;

  typedef struct packed {
    logic [1:0]  own;
    logic [3:0]  ctl;
    logic [31:0] dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cnt_clr = 1'b0;
  logic [1:0] arb_own;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] cnt_m [2];
  exp_t       exp_q [$];
`ifdef SOCKIT_SPI_ARB_RR_EN
  bit         ptr_m = 1'b0;
`endif

  always #5 clk = ~clk;

  sockit_spi_arb_if #(.QCI(4), .QDW(32)) s0_if ();
  sockit_spi_arb_if #(.QCI(4), .QDW(32)) s1_if ();
  sockit_spi_arb_if #(.QCI(4), .QDW(32)) que_if ();

  sockit_spi_arb dut (
    .clk     (clk),
    .rst     (rst),
    .s0      (s0_if),
    .s1      (s1_if),
    .que     (que_if),
    .arb_own (arb_own),
    .cnt_clr (cnt_clr),
    .cnt0    (cnt0),
    .cnt1    (cnt1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && que_if.req && que_if.grt) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_xfer: got own=%b dat=%0h expected no transfer (t=%0t)",
                 arb_own, que_if.dat, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("xfer_own", 64'(arb_own), 64'(e.own));
        chk("xfer_ctl", 64'(que_if.ctl), 64'(e.ctl));
        chk("xfer_dat", 64'(que_if.dat), 64'(e.dat));
        chk("xfer_other_grt", 64'((e.own == 2'b01) ? s1_if.grt : s0_if.grt), 64'd0);
        $display("xfer own=%b ctl=%b dat=%08h", arb_own, que_if.ctl, que_if.dat);
      end
    end
  end

  // Drive one segment on port p and wait for its transfer; n = negedges waited.
  task automatic beat(input int p, input bit nw, input bit lst, input logic [31:0] d,
                      output int n);
    exp_t       e;
    logic [3:0] c;
    c = {nw, lst, 2'b10};
    if (p == 0) begin
      s0_if.req = 1'b1; s0_if.ctl = c; s0_if.dat = d;
    end else begin
      s1_if.req = 1'b1; s1_if.ctl = c; s1_if.dat = d;
    end
    e.own = (p == 0) ? 2'b01 : 2'b10;
    e.ctl = c;
    e.dat = d;
    exp_q.push_back(e);
`ifdef SOCKIT_SPI_ARB_RR_EN
    if (nw) ptr_m = (p == 1);
`endif
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(arb_own == e.own && que_if.grt) && n < 50);
    if (n >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_timeout: got no transfer on port %0d expected one within 50 cycles", p);
    end
    @(posedge clk);
    #1;
    if (lst) begin
      if (p == 0) s0_if.req = 1'b0; else s1_if.req = 1'b0;
      cnt_m[p]++;
    end
  endtask

  initial begin
    int n;
    exp_t e;
    s0_if.req = 0; s0_if.ctl = 0; s0_if.dat = 0;
    s1_if.req = 0; s1_if.ctl = 0; s1_if.dat = 0;
    que_if.grt = 1'b1;
    cnt_m[0] = 0; cnt_m[1] = 0;

    // Reset state, with port 0 already requesting
    #2 rst = 1'b0;
    s0_if.req = 1'b1;
    #1;
    chk("rst_own", 64'(arb_own), 64'd0);
    chk("rst_que_req", 64'(que_if.req), 64'd0);
    chk("rst_s0_grt", 64'(s0_if.grt), 64'd0);
    chk("rst_cnt", 64'({cnt0, cnt1}), 64'd0);
    s0_if.req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Single 3-segment packet on port 0
    beat(0, 1, 0, 32'hA000_0001, n); chk("p0_latency", 64'(n), 64'd2);
    beat(0, 0, 0, 32'hA000_0002, n); chk("p0_beat2", 64'(n), 64'd1);
    beat(0, 0, 1, 32'hA000_0003, n); chk("p0_beat3", 64'(n), 64'd1);
    @(negedge clk);
    chk("p0_idle", 64'(arb_own), 64'd0);
    chk("p0_cnt0", 64'(cnt0), 64'd1);
    @(posedge clk); #1;

    // Port 1 requests while port 0 owns a 4-segment packet
    beat(0, 1, 0, 32'hB000_0001, n);
    s1_if.req = 1'b1; s1_if.ctl = 4'b1110; s1_if.dat = 32'hC000_0001;
    beat(0, 0, 0, 32'hB000_0002, n);
    beat(0, 0, 0, 32'hB000_0003, n);
    beat(0, 0, 1, 32'hB000_0004, n);
    beat(1, 1, 1, 32'hC000_0001, n); chk("dead_cycle", 64'(n), 64'd2);
    chk("ilv_cnt", 64'({cnt0, cnt1}), 64'({cnt_m[0], cnt_m[1]}));

    // Counter wrap and clear-wins
    cnt_clr = 1'b1; @(posedge clk); #1; cnt_clr = 1'b0;
    cnt_m[0] = 0; cnt_m[1] = 0;
    for (int i = 0; i < 255; i++) beat(1, 1, 1, 32'(i), n);
    @(negedge clk); chk("cnt1_255", 64'(cnt1), 64'd255);
    @(posedge clk); #1;
    beat(1, 1, 1, 32'hD000_0000, n);
    @(negedge clk); chk("cnt1_wrap", 64'(cnt1), 64'd0);
    @(posedge clk); #1;
    beat(1, 1, 1, 32'hD000_0001, n);
    @(negedge clk); chk("cnt1_one", 64'(cnt1), 64'(cnt_m[1]));
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    beat(1, 1, 1, 32'hD000_0002, n);
    cnt_clr = 1'b0;
    cnt_m[0] = 0; cnt_m[1] = 0;
    @(negedge clk); chk("cnt1_clr_wins", 64'(cnt1), 64'd0);
    @(posedge clk); #1;

    // Simultaneous 1-segment requests, 4 packets
    s0_if.req = 1; s0_if.ctl = 4'b1110; s0_if.dat = 32'hE000_0000;
    s1_if.req = 1; s1_if.ctl = 4'b1110; s1_if.dat = 32'hE000_0001;
    for (int k = 0; k < 4; k++) begin
      bit w;
`ifdef SOCKIT_SPI_ARB_RR_EN
      w = ~ptr_m;
      ptr_m = w;
`else
      w = 1'b0;
`endif
      e.own = w ? 2'b10 : 2'b01;
      e.ctl = 4'b1110;
      e.dat = w ? 32'hE000_0001 : 32'hE000_0000;
      exp_q.push_back(e);
      cnt_m[w]++;
    end
    repeat (8) @(posedge clk);
    #1;
    s0_if.req = 0; s1_if.req = 0;
    @(negedge clk);
    chk("sim_cnt0", 64'(cnt0), 64'(cnt_m[0]));
    chk("sim_cnt1", 64'(cnt1), 64'(cnt_m[1]));
    @(posedge clk); #1;

    // Owner drops request mid-packet, then queue withholds grant
    beat(1, 1, 0, 32'hF000_0001, n);
    s1_if.req = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_req_own", 64'(arb_own), 64'b10);
    end
    chk("stall_req_cnt", 64'(cnt1), 64'(cnt_m[1]));
    @(posedge clk); #1;
    que_if.grt = 1'b0;
    fork
      beat(1, 0, 1, 32'hF000_0002, n);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_grt_own", 64'(arb_own), 64'b10);
          chk("stall_grt_s1_grt", 64'(s1_if.grt), 64'd0);
        end
        @(posedge clk); #1;
        que_if.grt = 1'b1;
      end
    join
    chk("stall_grt_wait", 64'(n), 64'd4);
    @(negedge clk); chk("stall_cnt1", 64'(cnt1), 64'(cnt_m[1]));
    @(posedge clk); #1;

    // Asynchronous reset mid-packet
    beat(0, 1, 0, 32'h1234_5678, n);
    #2 rst = 1'b0;
    #1;
    chk("arst_own", 64'(arb_own), 64'd0);
    chk("arst_que_req", 64'(que_if.req), 64'd0);
    chk("arst_grt", 64'({s0_if.grt, s1_if.grt}), 64'd0);
    chk("arst_cnt", 64'({cnt0, cnt1}), 64'd0);
    s0_if.req = 1'b0;
    cnt_m[0] = 0; cnt_m[1] = 0;
`ifdef SOCKIT_SPI_ARB_RR_EN
    ptr_m = 1'b0;
`endif
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    beat(1, 1, 1, 32'h8765_4321, n); chk("arst_relatency", 64'(n), 64'd2);
    @(negedge clk); chk("arst_cnt1", 64'(cnt1), 64'd1);

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sockit_spi_arb.md
# sockit_spi_arb

Two-port packet arbiter sharing the SPI queue interface between a register-access source (port 0) and an XIP/DMA source (port 1). Ownership is granted per packet: once a source wins, it keeps the queue until it transfers a segment with the last flag set, so segments from the two sources never interleave. Sits directly upstream of the queue input of the SPI serializer/repackager chain. Keeps per-port completed-packet counters for software status.

## Interface
- `SDW`, 8, serial data register width
- `QCI`, 4, queue control width
- `QDW`, 4*SDW, queue data width
- `CNW`, 8, packet counter width
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `s0_req`  in  1  port 0 request
- `s0_ctl`  in  QCI  port 0 control ({new, lst, iom[1:0]})
- `s0_dat`  in  QDW  port 0 data
- `s0_grt`  out  1  port 0 grant
- `s1_req`, `s1_ctl`, `s1_dat`, `s1_grt`: same as port 0, for port 1
- `que_req`  out  1  queue request
- `que_ctl`  out  QCI  queue control
- `que_dat`  out  QDW  queue data
- `que_grt`  in  1  queue grant
- `arb_own`  out  2  one-hot current owner (00 = idle)
- `cnt_clr`  in  1  synchronous clear of both packet counters
- `cnt0`  out  CNW  completed packets, port 0
- `cnt1`  out  CNW  completed packets, port 1

## Operation
- FSM states IDLE, OWN0, OWN1; reset state IDLE.
- IDLE: `que_req`=0, `que_ctl`=0, `que_dat`=0, `s0_grt`=`s1_grt`=0. If any `sx_req`=1, register the winner and move to OWNx on the next edge. With no request, stay in IDLE.
- OWNx: combinational pass-through. `que_req`=`sx_req`, `que_ctl`=`sx_ctl`, `que_dat`=`sx_dat`, `sx_grt`=`que_grt`. The non-owner grant is forced to 0.
- A transfer is `que_req & que_grt` while in OWNx.
  - Transfer with `sx_ctl[2]`=1: return to IDLE and increment `cntx`.
  - Transfer with `sx_ctl[2]`=0: stay in OWNx.
- If the owner deasserts `sx_req` mid-packet, ownership is held indefinitely. There is no timeout, and the other port waits.
- Counters wrap modulo 2^CNW (for example, 255 -> 0 with CNW=8).
- If `cnt_clr` and an increment occur in the same cycle, `cnt_clr` wins and the counter reads 0.
- `arb_own`: 01 in OWN0, 10 in OWN1, 00 in IDLE.
- Winner selection in IDLE is set by the configuration below. A single requester always wins.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM to IDLE, `arb_own`=00, `cnt0`=`cnt1`=0, round-robin pointer = port 0.
  - All grant and request outputs go to 0 immediately, without waiting for a clock edge.
- Arbitration latency is 1 cycle. Request seen in IDLE at edge N gives OWNx after N, so `que_req` can first be high in cycle N+1.
- Back-to-back packets: a last-segment transfer at edge M gives IDLE after M. The next owner is selected at M+1, so there is exactly one dead cycle between packets.
- `sx_grt` depends combinationally on `que_grt`, and `que_req` on `sx_req`. No registers are in the data path.
- Reset asserted mid-packet aborts ownership. After release the FSM restarts from IDLE, and any partial packet is the upstream's responsibility.

## Configuration
- `SOCKIT_SPI_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer records the last winner.
  - When both ports request in IDLE, the port not pointed to wins.
  - The pointer updates when ownership is taken.
- `SOCKIT_SPI_ARB_RR_EN` undefined: fixed priority. Port 0 always wins simultaneous requests, and no pointer register exists.

## Test plan
- Single packet on port 0:
  - Stimulus: 3 segments, `s0_ctl` lst=0,0,1 with `que_grt`=1.
  - Response: `arb_own`=01 from cycle 1 to the third transfer, `que_dat` equals `s0_dat` each beat, `cnt0`=1, return to IDLE.
- No interleaving:
  - Stimulus: port 1 requests while port 0 owns a 4-segment packet.
  - Response: `s1_grt`=0 throughout; port 1 is granted only after the one dead cycle following port 0's lst transfer.
- Simultaneous requests:
  - Stimulus: both ports request continuously with 1-segment packets.
  - Response with RR_EN: owners alternate 0,1,0,1 and each counter reaches 2 after 4 packets.
  - Response without RR_EN: port 0 wins every time and `cnt1`=0.
- Stalls:
  - Stimulus: owner drops `sx_req` for 5 cycles mid-packet, and separately `que_grt`=0 for 3 cycles.
  - Response: `arb_own` is unchanged in both cases, with no counter increment and no transfers during the stall.
- Counter edges:
  - Stimulus: 255 packets on port 1 with CNW=8, then one more, then `cnt_clr` asserted in the same cycle as a lst transfer.
  - Response: `cnt1` reads 255, then 0, then 0.
- Asynchronous reset:
  - Stimulus: `rst`=0 asserted mid-packet between clock edges.
  - Response: `arb_own`, `que_req`, `s0_grt`, `s1_grt` and both counters go to 0 immediately. After release, a new request is granted with 1-cycle latency.
